// File: rtl/spi_mgmt_regbridge.sv
// rtl/spi_mgmt_regbridge.sv - SPI byte stream to addressed register window bridge (burst read/write)
// Optional: define MGMT_BRIDGE_SNAPSHOT_EN for coherent multi-byte reads through a shadow word.
module spi_mgmt_regbridge #(
    parameter int NUM_REGS  = 16,
    parameter int REG_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          spi_rx_data_valid,
    input  logic [7:0]                    spi_rx_data,
    input  logic                          spi_cs_falling,
    output logic                          spi_tx_data_valid,
    output logic [7:0]                    spi_tx_data,
    input  logic [NUM_REGS*REG_WIDTH-1:0] rd_data,
    output logic                          wr_en,
    output logic [7:0]                    wr_addr,
    output logic [REG_WIDTH-1:0]          wr_data,
    output logic                          bad_addr
);
    localparam int         BPR      = REG_WIDTH / 8;
    localparam logic [2:0] LAST_IDX = 3'(BPR - 1);
    localparam logic [8:0] NREGS    = 9'(NUM_REGS);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_READ, S_WRITE} state_t;

    state_t               r_state,    w_state_nx;
    logic [7:0]           r_addr,     w_addr_nx;
    logic [2:0]           r_byte_idx, w_byte_idx_nx;
    logic [REG_WIDTH-1:0] r_word,     w_word_nx;
    logic                 r_tx_valid, w_tx_valid_nx;
    logic [7:0]           r_tx_data,  w_tx_data_nx;
    logic                 r_wr_en,    w_wr_en_nx;
    logic [7:0]           r_wr_addr,  w_wr_addr_nx;
    logic [REG_WIDTH-1:0] r_wr_data,  w_wr_data_nx;
    logic                 r_bad,      w_bad_nx;
    logic                 w_emit;
    logic [REG_WIDTH-1:0] w_cur_word, w_src_word, w_word_asm;
    logic [7:0]           w_emit_byte;
    logic                 w_in_range, w_last;
`ifdef MGMT_BRIDGE_SNAPSHOT_EN
    logic [REG_WIDTH-1:0] r_shadow, w_shadow_nx;
`endif

    // Out-of-window indices select nothing and read as zero.
    always_comb begin
        w_cur_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (r_addr == 8'(i)) w_cur_word = rd_data[i*REG_WIDTH +: REG_WIDTH];
        end
    end

`ifdef MGMT_BRIDGE_SNAPSHOT_EN
    assign w_src_word = (r_byte_idx == 3'd0) ? w_cur_word : r_shadow;
`else
    assign w_src_word = w_cur_word;
`endif

    assign w_in_range  = ({1'b0, r_addr} < NREGS);
    assign w_emit_byte = w_in_range ? 8'(w_src_word >> {r_byte_idx, 3'b000}) : 8'h00;
    assign w_last      = (r_byte_idx == LAST_IDX);
    assign w_word_asm  = ((r_byte_idx == 3'd0) ? '0 : r_word)
                       | (REG_WIDTH'(spi_rx_data) << {r_byte_idx, 3'b000});

    always_comb begin
        w_state_nx    = r_state;
        w_addr_nx     = r_addr;
        w_byte_idx_nx = r_byte_idx;
        w_word_nx     = r_word;
        w_tx_valid_nx = 1'b0;
        w_tx_data_nx  = r_tx_data;
        w_wr_en_nx    = 1'b0;
        w_wr_addr_nx  = r_wr_addr;
        w_wr_data_nx  = r_wr_data;
        w_bad_nx      = 1'b0;
        w_emit        = 1'b0;
`ifdef MGMT_BRIDGE_SNAPSHOT_EN
        w_shadow_nx   = r_shadow;
`endif
        if (spi_cs_falling) begin
            w_state_nx    = S_IDLE;
            w_byte_idx_nx = 3'd0;
            w_word_nx     = '0;
            w_tx_data_nx  = 8'h00;
        end else if (spi_rx_data_valid) begin
            unique case (r_state)
                S_IDLE: begin
                    w_addr_nx     = spi_rx_data;
                    w_byte_idx_nx = 3'd0;
                    w_state_nx    = S_HDR;
                end
                S_HDR: begin
                    if (spi_rx_data[7]) begin
                        w_state_nx = S_WRITE;
                    end else begin
                        w_state_nx = S_READ;
                        w_emit     = 1'b1;
                    end
                end
                S_READ: w_emit = 1'b1;
                S_WRITE: begin
                    w_word_nx = w_word_asm;
                    if (w_last) begin
                        if (w_in_range) begin
                            w_wr_en_nx   = 1'b1;
                            w_wr_addr_nx = r_addr;
                            w_wr_data_nx = w_word_asm;
                        end else begin
                            w_bad_nx = 1'b1;
                        end
                        w_addr_nx     = r_addr + 8'd1;
                        w_byte_idx_nx = 3'd0;
                    end else begin
                        w_byte_idx_nx = r_byte_idx + 3'd1;
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
        end

        // Shared by the header-1 byte and every dummy byte while reading.
        if (w_emit) begin
            w_tx_valid_nx = 1'b1;
            w_tx_data_nx  = w_emit_byte;
            if (r_byte_idx == 3'd0) begin
                w_bad_nx = !w_in_range;
`ifdef MGMT_BRIDGE_SNAPSHOT_EN
                w_shadow_nx = w_cur_word;
`endif
            end
            if (w_last) begin
                w_addr_nx     = r_addr + 8'd1;
                w_byte_idx_nx = 3'd0;
            end else begin
                w_byte_idx_nx = r_byte_idx + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= 8'h00;
            r_byte_idx <= 3'd0;
            r_word     <= '0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= 8'h00;
            r_wr_data  <= '0;
            r_bad      <= 1'b0;
`ifdef MGMT_BRIDGE_SNAPSHOT_EN
            r_shadow   <= '0;
`endif
        end else begin
            r_state    <= w_state_nx;
            r_addr     <= w_addr_nx;
            r_byte_idx <= w_byte_idx_nx;
            r_word     <= w_word_nx;
            r_tx_valid <= w_tx_valid_nx;
            r_tx_data  <= w_tx_data_nx;
            r_wr_en    <= w_wr_en_nx;
            r_wr_addr  <= w_wr_addr_nx;
            r_wr_data  <= w_wr_data_nx;
            r_bad      <= w_bad_nx;
`ifdef MGMT_BRIDGE_SNAPSHOT_EN
            r_shadow   <= w_shadow_nx;
`endif
        end
    end

    assign spi_tx_data_valid = r_tx_valid;
    assign spi_tx_data       = r_tx_data;
    assign wr_en             = r_wr_en;
    assign wr_addr           = r_wr_addr;
    assign wr_data           = r_wr_data;
    assign bad_addr          = r_bad;

endmodule

// File: tb/tb_spi_mgmt_regbridge.sv
// tb/tb_spi_mgmt_regbridge.sv - randomized self-checking bench for spi_mgmt_regbridge
module tb_spi_mgmt_regbridge;
    localparam int NR  = 16;
    localparam int RW  = 32;
    localparam int BPR = RW / 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              spi_rx_data_valid = 1'b0;
    logic [7:0]        spi_rx_data = 8'h00;
    logic              spi_cs_falling = 1'b0;
    logic              spi_tx_data_valid;
    logic [7:0]        spi_tx_data;
    logic [NR*RW-1:0]  rd_data;
    logic              wr_en;
    logic [7:0]        wr_addr;
    logic [RW-1:0]     wr_data;
    logic              bad_addr;

    logic [RW-1:0]     regs [NR];
    logic [7:0]        wq [$];
    int                n_cmp = 0;
    int                n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NR; g++) begin : g_rd
        assign rd_data[g*RW +: RW] = regs[g];
    end

    spi_mgmt_regbridge #(.NUM_REGS(NR), .REG_WIDTH(RW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .spi_rx_data_valid (spi_rx_data_valid),
        .spi_rx_data       (spi_rx_data),
        .spi_cs_falling    (spi_cs_falling),
        .spi_tx_data_valid (spi_tx_data_valid),
        .spi_tx_data       (spi_tx_data),
        .rd_data           (rd_data),
        .wr_en             (wr_en),
        .wr_addr           (wr_addr),
        .wr_data           (wr_data),
        .bad_addr          (bad_addr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reply byte j of a read burst starting at index start.
    function automatic logic [7:0] model_byte(input int start, input int j);
        int idx;
        int b;
        idx = (start + j / BPR) % 256;
        b   = j % BPR;
        if (idx >= NR) return 8'h00;
        return 8'(regs[idx] >> (8 * b));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rx(input logic [7:0] b);
        spi_rx_data_valid = 1'b1;
        spi_rx_data       = b;
        step();
        spi_rx_data_valid = 1'b0;
    endtask

    task automatic cs();
        spi_cs_falling = 1'b1;
        step();
        spi_cs_falling = 1'b0;
        check("cs_txv", spi_tx_data_valid, 0);
        check("cs_txd", spi_tx_data, 0);
        check("cs_wen", wr_en, 0);
    endtask

    task automatic maybe_gap();
        if ($urandom_range(0, 3) == 0) begin
            step();
            check("gap_txv", spi_tx_data_valid, 0);
            check("gap_wen", wr_en, 0);
            check("gap_bad", bad_addr, 0);
        end
    endtask

    task automatic read_body(input logic [7:0] a, input int nbytes);
        logic [31:0] r;
        int ia;
        ia = int'(a);
        rx(a);
        check("hdr0_txv", spi_tx_data_valid, 0);
        r = $urandom;
        rx({1'b0, r[6:0]});
        for (int j = 0; j < nbytes; j++) begin
            if (j > 0) begin
                maybe_gap();
                r = $urandom;
                rx(r[7:0]);
            end
            check("rd_txv", spi_tx_data_valid, 1);
            check("rd_txd", spi_tx_data, model_byte(ia, j));
            check("rd_bad", bad_addr, (j % BPR == 0) && (((ia + j / BPR) % 256) >= NR));
            check("rd_wen", wr_en, 0);
        end
    endtask

    task automatic write_body(input logic [7:0] a);
        logic [31:0]   r;
        logic [RW-1:0] word;
        int idx;
        rx(a);
        check("whdr0_txv", spi_tx_data_valid, 0);
        r = $urandom;
        rx({1'b1, r[6:0]});
        check("whdr1_txv", spi_tx_data_valid, 0);
        word = '0;
        for (int k = 0; k < wq.size(); k++) begin
            if (k > 0) maybe_gap();
            rx(wq[k]);
            if (k % BPR == 0) word = '0;
            word[8*(k % BPR) +: 8] = wq[k];
            idx = (int'(a) + k / BPR) % 256;
            check("wr_txv", spi_tx_data_valid, 0);
            if (k % BPR == BPR - 1 && idx < NR) begin
                check("wr_wen", wr_en, 1);
                check("wr_addr", wr_addr, idx);
                check("wr_data", wr_data, word);
                check("wr_bad", bad_addr, 0);
            end else if (k % BPR == BPR - 1) begin
                check("wr_oor_wen", wr_en, 0);
                check("wr_oor_bad", bad_addr, 1);
            end else begin
                check("wr_mid_wen", wr_en, 0);
                check("wr_mid_bad", bad_addr, 0);
            end
        end
        cs();
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0]  a;
        for (int i = 0; i < NR; i++) regs[i] = $urandom;

        step();
        step();
        check("rst_txv", spi_tx_data_valid, 0);
        check("rst_txd", spi_tx_data, 0);
        check("rst_wen", wr_en, 0);
        check("rst_waddr", wr_addr, 0);
        check("rst_wdata", wr_data, 0);
        check("rst_bad", bad_addr, 0);
        rst_n = 1'b1;
        step();

        regs[2] = 32'hDEADBEEF;
        cs();
        read_body(8'd2, 4);
        check("deadbeef_last", spi_tx_data, 8'hDE);

        cs();
        read_body(8'd15, 8);
        cs();
        read_body(8'hFF, 8);

        wq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        cs();
        write_body(8'd3);
        check("w8003_last", wr_data, 32'h88776655);

        wq = '{8'hAA, 8'hBB};
        cs();
        write_body(8'd1);
        read_body(8'd1, 4);

        cs();
        regs[0] = 32'h11111111;
        rx(8'h00);
        rx(8'h00);
        check("snap_b0", spi_tx_data, 8'h11);
        regs[0] = 32'h22222222;
        for (int j = 1; j < BPR; j++) begin
            rx(8'h5A);
            check("snap_txv", spi_tx_data_valid, 1);
`ifdef MGMT_BRIDGE_SNAPSHOT_EN
            check("snap_bn", spi_tx_data, 8'h11);
`else
            check("snap_bn", spi_tx_data, 8'h22);
`endif
        end

        cs();
        read_body(8'd6, 1);
        spi_cs_falling    = 1'b1;
        spi_rx_data_valid = 1'b1;
        spi_rx_data       = 8'h07;
        step();
        spi_cs_falling    = 1'b0;
        spi_rx_data_valid = 1'b0;
        check("csrx_txv", spi_tx_data_valid, 0);
        check("csrx_txd", spi_tx_data, 0);
        read_body(8'd9, 4);

        cs();
        read_body(8'd3, 2);
        spi_rx_data_valid = 1'b1;
        spi_rx_data       = 8'h00;
        rst_n             = 1'b0;
        #1;
        check("mrst_txv", spi_tx_data_valid, 0);
        check("mrst_txd", spi_tx_data, 0);
        check("mrst_wen", wr_en, 0);
        check("mrst_waddr", wr_addr, 0);
        check("mrst_wdata", wr_data, 0);
        check("mrst_bad", bad_addr, 0);
        step();
        spi_rx_data_valid = 1'b0;
        rst_n             = 1'b1;
        step();
        read_body(8'd4, 4);

        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < NR; i++) regs[i] = $urandom;
            r = $urandom;
            a = r[7:0];
            if (it % 2 == 1) a = a % 8'd20;
            cs();
            if ($urandom_range(0, 1) == 0) begin
                read_body(a, $urandom_range(1, 12));
            end else begin
                wq.delete();
                for (int k = 0; k < $urandom_range(1, 10); k++) begin
                    r = $urandom;
                    wq.push_back(r[7:0]);
                end
                write_body(a);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
